// File: rtl/add_serial_if.sv
// Start/done handshake and operand/result bus of the serial adder.
//   start, rs1_reg, rs2_reg, cin : request and operands (master -> slave)
//   busy, done, add_rd, co       : status and result    (slave -> master)
interface add_serial_if #(
    parameter int unsigned N = 16
);
    logic         start;
    logic [N-1:0] rs1_reg;
    logic [N-1:0] rs2_reg;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] add_rd;
    logic         co;

    modport master (
        output start, rs1_reg, rs2_reg, cin,
        input  busy, done, add_rd, co
    );

    modport slave (
        input  start, rs1_reg, rs2_reg, cin,
        output busy, done, add_rd, co
    );
endinterface

// File: rtl/add_serial.sv
// Multi-cycle ripple adder: W bits per clock, LSB slice first, start/done handshake.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : add_serial_if slave (start, rs1_reg, rs2_reg, cin -> busy, done, add_rd, co)
// add_rd = (rs1_reg + rs2_reg + cin) mod 2^N, co = carry out of bit N-1.
module add_serial #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    add_serial_if.slave  bus
);
    localparam int unsigned SLICES = N / W;
    localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    if ((N % W) != 0) begin : g_bad_width
        $fatal(1, "add_serial: N must be a multiple of W");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic [N-1:0]       sum_q;
    logic [N-1:0]       add_rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               co_q;
    logic               busy_q;
    logic               done_q;

    logic [W:0]         slice_sum;
    logic [N-1:0]       sum_next;
    logic               last;

    // Operands are shifted right each RUN edge, so the current slice is always
    // in the low W bits; finished slices enter the partial sum from the top.
    always_comb begin
        slice_sum = (W+1)'(a_q[W-1:0]) + (W+1)'(b_q[W-1:0]) + (W+1)'(carry_q);
        sum_next  = (sum_q >> W) | (N'(slice_sum[W-1:0]) << (N - W));
        last      = (cnt_q == CNT_W'(SLICES - 1));
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            add_rd_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            co_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.rs1_reg;
                        b_q     <= bus.rs2_reg;
                        carry_q <= bus.cin;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> W;
                    b_q     <= b_q >> W;
                    carry_q <= slice_sum[W];
                    sum_q   <= sum_next;
                    cnt_q   <= CNT_W'(cnt_q + 1'b1);
                    if (last) begin
                        add_rd_q <= sum_next;
                        co_q     <= slice_sum[W];
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.add_rd = add_rd_q;
    assign bus.co     = co_q;
endmodule
